// File: rtl/mtimer_pkg.sv
// Shared constants for the machine timer: register offsets, IRQ bit indices
// shared with CLINT, and reset values.
package mtimer_pkg;

  typedef enum logic [2:0] {
    MTIME_LO    = 3'd0,
    MTIME_HI    = 3'd1,
    MTIMECMP_LO = 3'd2,
    MTIMECMP_HI = 3'd3,
    CTRL        = 3'd4,
    MSIP        = 3'd5,
    RSVD6       = 3'd6,
    RSVD7       = 3'd7
  } reg_e;

  localparam int unsigned IRQ_TIMER = 0;
  localparam int unsigned IRQ_SOFT  = 1;
  localparam int unsigned IRQ_W     = 8;

  localparam logic [63:0] MTIMECMP_RST = '1;

  // ctrl register layout: prescale in [31:16], enable in [0]
  function automatic logic [31:0] ctrl_word(input logic [15:0] prescale, input logic en);
    return {prescale, 15'b0, en};
  endfunction

endpackage

// File: rtl/mtimer_if.sv
// Data-memory bus slice seen by the machine timer (MEM-stage access).
interface mtimer_if;
  logic [31:0] addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        sel;

  modport master (output addr, we, re, wdata, input rdata, rvalid, sel);
  modport slave  (input addr, we, re, wdata, output rdata, rvalid, sel);
endinterface

// File: rtl/mtimer_prescaler.sv
// Programmable divider producing one mtime tick every (prescale + 1) enabled cycles.
module mtimer_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] prescale,
  input  logic        clr,
  output logic        tick
);

  logic [15:0] pcnt;

  assign tick = en && (pcnt == prescale);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= tick ? '0 : pcnt + 16'd1;
    end
  end

endmodule

// File: rtl/mtimer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, prescaler, msip,
// registered level interrupt requests to CLINT.
module mtimer
  import mtimer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic          clk,
  input  logic          rst,
  mtimer_if.slave       bus,
  output logic [IRQ_W-1:0] interrupt_flag
);

  logic [31:0] time_lo;
  logic [31:0] time_hi;
  logic [31:0] cmp_lo;
  logic [31:0] cmp_hi;
  logic [31:0] shadow;
  logic [15:0] prescale;
  logic        en;
  logic        msip;
  logic        tick;

  reg_e        idx;
  logic        wr;
  logic        rd;
  logic        ctrl_wr;
  logic [32:0] lo_inc;
  logic [31:0] rd_val;
  logic [IRQ_W-1:0] irq_next;
  logic [1:0]  unused_addr;

  assign unused_addr = bus.addr[1:0];

  assign bus.sel = (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign idx     = reg_e'(bus.addr[4:2]);
  assign wr      = bus.sel && bus.we;
  assign rd      = bus.sel && bus.re;
  assign ctrl_wr = wr && (idx == CTRL);

  mtimer_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .prescale (prescale),
    .clr      (ctrl_wr),
    .tick     (tick)
  );

  assign lo_inc = {1'b0, time_lo} + {32'b0, tick};

  // Read mux uses pre-edge values, so a same-cycle write returns the old value.
  always_comb begin
    rd_val = '0;
    case (idx)
      MTIME_LO:    rd_val = time_lo;
      MTIME_HI:    rd_val = shadow;
      MTIMECMP_LO: rd_val = cmp_lo;
      MTIMECMP_HI: rd_val = cmp_hi;
      CTRL:        rd_val = ctrl_word(prescale, en);
      MSIP:        rd_val = {31'b0, msip};
      default:     rd_val = '0;
    endcase
  end

  always_comb begin
    irq_next            = '0;
    irq_next[IRQ_TIMER] = ({time_hi, time_lo} >= {cmp_hi, cmp_lo});
    irq_next[IRQ_SOFT]  = msip;
  end

  // A lo write suppresses the tick entirely; a hi write lets lo tick but drops its carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      time_lo <= '0;
      time_hi <= '0;
    end else if (wr && (idx == MTIME_LO)) begin
      time_lo <= bus.wdata;
    end else if (wr && (idx == MTIME_HI)) begin
      time_hi <= bus.wdata;
      time_lo <= lo_inc[31:0];
    end else begin
      time_lo <= lo_inc[31:0];
      time_hi <= time_hi + {31'b0, lo_inc[32]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_lo   <= MTIMECMP_RST[31:0];
      cmp_hi   <= MTIMECMP_RST[63:32];
      en       <= 1'b0;
      prescale <= '0;
      msip     <= 1'b0;
    end else if (wr) begin
      case (idx)
        MTIMECMP_LO: cmp_lo <= bus.wdata;
        MTIMECMP_HI: cmp_hi <= bus.wdata;
        CTRL: begin
          en       <= bus.wdata[0];
          prescale <= bus.wdata[31:16];
        end
        MSIP:        msip <= bus.wdata[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rdata      <= '0;
      bus.rvalid     <= 1'b0;
      shadow         <= '0;
      interrupt_flag <= '0;
    end else begin
      bus.rvalid     <= rd;
      interrupt_flag <= irq_next;
      if (rd) begin
        bus.rdata <= rd_val;
      end
      if (rd && (idx == MTIME_LO)) begin
        shadow <= time_hi;
      end
    end
  end

endmodule
